// File: rtl/sip_accumulator_pkg.sv
// Shared widths and helpers for the SIP accumulator.
// Optional feature macro: SIP_ACC_SAT_EN (saturating adds instead of wrap-around).
// Width macros BITS_SIP_DOT_ADDER, BITS_PARALLEL and BITS_SIP_ACC fall back to defaults
// here when no global parameters file has defined them.

`ifndef BITS_SIP_DOT_ADDER
`define BITS_SIP_DOT_ADDER 16
`endif
`ifndef BITS_PARALLEL
`define BITS_PARALLEL 2
`endif
`ifndef BITS_SIP_ACC
`define BITS_SIP_ACC 32
`endif

package sip_accumulator_pkg;

  localparam int unsigned BitsSipDotAdder = `BITS_SIP_DOT_ADDER;
  localparam int unsigned BitsParallel    = `BITS_PARALLEL;
  localparam int unsigned BitsSipAcc      = `BITS_SIP_ACC;
  localparam int unsigned DefaultCntW     = 3;

  // Largest shift reachable: both chunk indices at their maximum.
  function automatic int unsigned max_shift(int unsigned shift_step, int unsigned cnt_w);
    return shift_step * 2 * ((1 << cnt_w) - 1);
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sip_accumulator_if.sv
// Handshake/data bundle between the SIP dot-adder side and the accumulator.
// slave is the accumulator's view, master the driver/consumer's view.

interface sip_accumulator_if
  import sip_accumulator_pkg::*;
#(
  parameter int unsigned IN_W  = BitsSipDotAdder,
  parameter int unsigned ACC_W = BitsSipAcc,
  parameter int unsigned CNT_W = DefaultCntW
);

  logic                    i_Start;
  logic [CNT_W-1:0]        i_NumA;
  logic [CNT_W-1:0]        i_NumW;
  logic                    i_Valid;
  logic signed [IN_W-1:0]  i_PSum;
  logic                    o_Ready;
  logic                    o_Valid;
  logic signed [ACC_W-1:0] o_Acc;
  logic                    i_OutReady;
  logic                    o_Busy;

  modport master (
    output i_Start, i_NumA, i_NumW, i_Valid, i_PSum, i_OutReady,
    input  o_Ready, o_Valid, o_Acc, o_Busy
  );

  modport slave (
    input  i_Start, i_NumA, i_NumW, i_Valid, i_PSum, i_OutReady,
    output o_Ready, o_Valid, o_Acc, o_Busy
  );

endinterface

// File: rtl/sip_acc_shifter.sv
// Combinational datapath: sign-extend a partial sum, shift it by its chunk significance
// and add it to the running accumulator.
// SIP_ACC_SAT_EN defined: result clamps to the signed ACC_W range; otherwise it wraps.

module sip_acc_shifter
  import sip_accumulator_pkg::*;
#(
  parameter int unsigned IN_W       = BitsSipDotAdder,
  parameter int unsigned ACC_W      = BitsSipAcc,
  parameter int unsigned SHIFT_STEP = BitsParallel,
  parameter int unsigned CNT_W      = DefaultCntW
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic signed [IN_W-1:0]  psum_i,
  input  logic [CNT_W:0]          idx_i,
  output logic signed [ACC_W-1:0] sum_o
);

  // One guard bit above the widest operand keeps the full-precision sum exact.
  localparam int unsigned FullW = max_u(ACC_W, IN_W + max_shift(SHIFT_STEP, CNT_W)) + 1;

  logic [FullW-1:0] psum_ext;
  logic [FullW-1:0] acc_ext;
  logic [FullW-1:0] shifted;
  logic [FullW-1:0] full_sum;
  int unsigned      shamt;

  assign psum_ext = {{(FullW - IN_W){psum_i[IN_W-1]}}, psum_i};
  assign acc_ext  = {{(FullW - ACC_W){acc_i[ACC_W-1]}}, acc_i};

  // Shift the sign-extended partial sum into place and add at full precision.
  always_comb begin
    shamt    = SHIFT_STEP * 32'(idx_i);
    shifted  = psum_ext << shamt;
    full_sum = acc_ext + shifted;
  end

`ifdef SIP_ACC_SAT_EN
  logic ovf;

  // Any disagreement among the bits above the ACC_W sign position means overflow.
  assign ovf = (full_sum[FullW-1:ACC_W-1] != {(FullW - ACC_W + 1){full_sum[FullW-1]}});

  // Clamp toward the sign of the exact result.
  always_comb begin
    sum_o = full_sum[ACC_W-1:0];
    if (ovf) begin
      sum_o = full_sum[FullW-1] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end
  end
`else
  logic unused_full_hi;

  assign sum_o          = full_sum[ACC_W-1:0];
  assign unused_full_hi = ^full_sum[FullW-1:ACC_W];
`endif

endmodule

// File: rtl/sip_accumulator.sv
// Multi-precision dot-product accumulator behind the SIP dot-adder.
// Accepts one partial sum per (activation chunk, weight chunk) pair, weights it by chunk
// significance and presents the total on a valid/ready output.
// Optional feature macro: SIP_ACC_SAT_EN (handled in sip_acc_shifter).

module sip_accumulator
  import sip_accumulator_pkg::*;
#(
  parameter int unsigned IN_W       = BitsSipDotAdder,
  parameter int unsigned ACC_W      = BitsSipAcc,
  parameter int unsigned SHIFT_STEP = BitsParallel,
  parameter int unsigned CNT_W      = DefaultCntW
) (
  input logic              i_CLK,
  input logic              i_RSTn,
  sip_accumulator_if.slave bus
);

  localparam logic [1:0] EncIdle = 2'd0;
  localparam logic [1:0] EncAcc  = 2'd1;
  localparam logic [1:0] EncOut  = 2'd2;

  typedef enum logic [1:0] {
    StIdle = EncIdle,
    StAcc  = EncAcc,
    StOut  = EncOut
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        a_q, a_d;
  logic [CNT_W-1:0]        w_q, w_d;
  logic [CNT_W-1:0]        num_a_q, num_a_d;
  logic [CNT_W-1:0]        num_w_q, num_w_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_sum;
  logic [CNT_W:0]          idx;

  // Combined chunk significance of the current beat.
  assign idx = {1'b0, a_q} + {1'b0, w_q};

  sip_acc_shifter #(
    .IN_W      (IN_W),
    .ACC_W     (ACC_W),
    .SHIFT_STEP(SHIFT_STEP),
    .CNT_W     (CNT_W)
  ) u_shifter (
    .acc_i (acc_q),
    .psum_i(bus.i_PSum),
    .idx_i (idx),
    .sum_o (acc_sum)
  );

  // Next-state: pass sequencing, chunk counters (a inner, w outer) and accumulation.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    w_d     = w_q;
    num_a_d = num_a_q;
    num_w_d = num_w_q;
    acc_d   = acc_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_Start) begin
          num_a_d = bus.i_NumA;
          num_w_d = bus.i_NumW;
          a_d     = '0;
          w_d     = '0;
          acc_d   = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        // o_Ready is always high here, so i_Valid alone marks an accepted beat.
        if (bus.i_Valid) begin
          acc_d = acc_sum;
          if (a_q == num_a_q) begin
            a_d = '0;
            w_d = w_q + CNT_W'(1);
            if (w_q == num_w_q) begin
              state_d = StOut;
            end
          end else begin
            a_d = a_q + CNT_W'(1);
          end
        end
      end
      StOut: begin
        if (bus.i_OutReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset discards any partial result.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q <= StIdle;
      a_q     <= '0;
      w_q     <= '0;
      num_a_q <= '0;
      num_w_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      w_q     <= w_d;
      num_a_q <= num_a_d;
      num_w_q <= num_w_d;
      acc_q   <= acc_d;
    end
  end

  // Outputs are pure functions of state so reset clears them without waiting for a clock.
  always_comb begin
    bus.o_Ready = (state_q == StAcc);
    bus.o_Valid = (state_q == StOut);
    bus.o_Busy  = (state_q != StIdle);
    bus.o_Acc   = acc_q;
  end

endmodule
